// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, result width and the result word type.
package alu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int OUT_WIDTH  = DATA_WIDTH + 3;

    typedef logic [OUT_WIDTH-1:0] alu_result_t;

endpackage

// File: rtl/alu_fifo_mem.sv
// Register array for the ALU result FIFO: synchronous write, combinational read.
// Contents are not reset; occupancy tracking in the parent decides what is valid.
module alu_fifo_mem #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer between the ALU result port and its consumer.
// Pointers carry one extra wrap bit so full and empty are told apart.
// Optional macro ALU_RESULT_FIFO_HWM_EN adds the o_HWM high-water-mark port.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = OUT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTn,
    input  logic                    i_VALID,
    output logic                    o_READY,
    input  logic [WIDTH-1:0]        i_DATA,
    output logic                    o_VALID,
    input  logic                    i_READY,
    output logic [WIDTH-1:0]        o_Y,
    output logic [$clog2(DEPTH):0]  o_COUNT
`ifdef ALU_RESULT_FIFO_HWM_EN
    ,
    output logic [$clog2(DEPTH):0]  o_HWM
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    logic          push;
    logic          pop;

    assign count      = wr_ptr - rd_ptr;
    assign o_VALID    = (count != '0);
    assign push       = i_VALID && o_READY;
    assign pop        = o_VALID && i_READY;
    assign count_next = count + PW'(push) - PW'(pop);
    assign o_COUNT    = count;

    alu_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (i_CLK),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (i_DATA),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (o_Y)
    );

    // Advance pointers on push/pop; o_READY is registered from next occupancy.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_READY <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_READY <= (count_next < DEPTH_C);
        end
    end

`ifdef ALU_RESULT_FIFO_HWM_EN
    // Track the largest occupancy seen since reset.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            o_HWM <= '0;
        end else if (count_next > o_HWM) begin
            o_HWM <= count_next;
        end
    end
`else
    // High-water mark not built.
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed testbench for alu_result_fifo (DEPTH=4, WIDTH=11).
module tb_alu_result_fifo;
    import alu_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    alu_result_t i_data;
    logic        o_valid;
    logic        i_ready;
    alu_result_t o_y;
    logic [2:0]  o_count;
`ifdef ALU_RESULT_FIFO_HWM_EN
    logic [2:0]  o_hwm;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(4)) dut (
        .i_CLK   (i_clk),
        .i_RSTn  (i_rst_n),
        .i_VALID (i_valid),
        .o_READY (o_ready),
        .i_DATA  (i_data),
        .o_VALID (o_valid),
        .i_READY (i_ready),
        .o_Y     (o_y),
        .o_COUNT (o_count)
`ifdef ALU_RESULT_FIFO_HWM_EN
        ,
        .o_HWM   (o_hwm)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_data  = 11'h0AA;
        i_ready = 1'b0;

        // 1. reset held for 3 cycles with i_VALID high
        repeat (3) tick();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_count", o_count, 0);
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        tick();
        check("rel_ready", o_ready, 1);
        check("rel_count", o_count, 0);

        // 2. fill with consumer stalled
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1;
            i_data  = 11'(k);
            tick();
            check("fill_count", o_count, 32'(k));
            check("fill_y",     o_y,     32'h001);
            check("fill_valid", o_valid, 1);
            check("fill_ready", o_ready, (k < 4) ? 1 : 0);
        end
        i_data = 11'h7FF;
        repeat (2) begin
            tick();
            check("full_count", o_count, 4);
            check("full_ready", o_ready, 0);
            check("full_y",     o_y,     32'h001);
        end

        // 3. drain in order
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_y",     o_y,     32'(k));
            check("drain_valid", o_valid, 1);
            tick();
            if (k == 1) check("drain_ready", o_ready, 1);
        end
        check("drained_valid", o_valid, 0);
        check("drained_count", o_count, 0);

        // 4. streaming through pointer wrap
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1;
            i_data  = 11'(k);
            tick();
            check("stream_y",     o_y,     32'(k));
            check("stream_valid", o_valid, 1);
            check("stream_count", o_count, 1);
            check("stream_ready", o_ready, 1);
        end
        i_valid = 1'b0;
        tick();
        check("stream_end_valid", o_valid, 0);
        check("stream_end_count", o_count, 0);

        // 5. mid-operation asynchronous reset
        i_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            i_valid = 1'b1;
            i_data  = 11'(k * 16);
            tick();
        end
        i_valid = 1'b0;
        check("pre_rst_count", o_count, 3);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_count", o_count, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_ready", o_ready, 0);
        #1 i_rst_n = 1'b1;
        tick();
        check("post_rst_ready", o_ready, 1);
        check("post_rst_valid", o_valid, 0);
        i_valid = 1'b1;
        i_data  = 11'h155;
        tick();
        check("post_rst_y",     o_y,     32'h155);
        check("post_rst_count", o_count, 1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("post_rst_empty", o_valid, 0);

`ifdef ALU_RESULT_FIFO_HWM_EN
        // 6. high-water mark
        i_rst_n = 1'b0;
        tick();
        check("hwm_rst0", o_hwm, 0);
        i_rst_n = 1'b1;
        tick();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = 11'(k);
            tick();
        end
        check("hwm_after_push3", o_hwm, 3);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        check("hwm_after_pop3", o_hwm, 3);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 11'h042;
        tick();
        i_valid = 1'b0;
        check("hwm_after_push1", o_hwm, 3);
        check("hwm_count", o_count, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check("hwm_reset", o_hwm, 0);
        #1 i_rst_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
